// File: rtl/revo_frame9_transmitter_pkg.sv
// Shared definitions for the revo/frame9 transmitter and its matching receiver.
// Holds the frame9 token start value, the nominal orbit length and the orbit
// counter width, plus small helpers for token rotation and length clamping.
package revo_frame9_transmitter_pkg;

    localparam int ORBIT_CTR_W = 11;
    localparam int DEFAULT_ORBIT_MINUS_ONE = 1279;
    localparam logic [8:0] FRAME9_TOKEN_INIT = 9'b100000000;

    // One step of the frame9 token: rotate right by one position.
    function automatic logic [8:0] rotate_token(input logic [8:0] token_in);
        return {token_in[0], token_in[8:1]};
    endfunction

    // Orbit length minus one, never shorter than the supplied floor.
    function automatic logic [ORBIT_CTR_W-1:0] clamp_orbit(
        input logic [ORBIT_CTR_W-1:0] len_in,
        input logic [ORBIT_CTR_W-1:0] floor_in
    );
        logic [ORBIT_CTR_W-1:0] result;
        if (len_in < floor_in) begin
            result = floor_in;
        end else begin
            result = len_in;
        end
        return result;
    endfunction

endpackage

// File: rtl/revo_frame9_transmitter_if.sv
// Control/status bundle of the revo/frame9 transmitter.
//   master : drives enable, orbit_length_minus_one, revo_mask, resync;
//            observes revo, frame9, revo_rise, revo_fall, orbit_count, token.
//   slave  : the transmitter side (directions reversed).
interface revo_frame9_transmitter_if;
    import revo_frame9_transmitter_pkg::*;

    logic                   enable;
    logic [ORBIT_CTR_W-1:0] orbit_length_minus_one;
    logic [8:0]             revo_mask;
    logic                   resync;
    logic                   revo;
    logic                   frame9;
    logic                   revo_rise;
    logic                   revo_fall;
    logic [31:0]            orbit_count;
    logic [8:0]             token;

    modport master (
        output enable, orbit_length_minus_one, revo_mask, resync,
        input  revo, frame9, revo_rise, revo_fall, orbit_count, token
    );

    modport slave (
        input  enable, orbit_length_minus_one, revo_mask, resync,
        output revo, frame9, revo_rise, revo_fall, orbit_count, token
    );

endinterface

// File: rtl/ddr_revo_output.sv
// DDR launch of the revo line as a differential pair.
// Ports: clock127 (launch clock), revo_rise (data for the clock-high half),
//        revo_fall (data for the clock-low half), remote_revo_p/remote_revo_n.
// This is the only place where the vendor ODDR2 + OBUFDS cells belong; the
// body here is their behavioural equivalent so the core simulates without
// any vendor library.
module ddr_revo_output (
    input  logic clock127,
    input  logic revo_rise,
    input  logic revo_fall,
    output logic remote_revo_p,
    output logic remote_revo_n
);

    // Half-cycle data select (ODDR2 behaviour) and differential split (OBUFDS).
    always_comb begin
        remote_revo_p = 1'b0;
        if (clock127) begin
            remote_revo_p = revo_rise;
        end else begin
            remote_revo_p = revo_fall;
        end
        remote_revo_n = ~remote_revo_p;
    end

endmodule

// File: rtl/revo_frame9_transmitter.sv
// Revolution (orbit) strobe generator with a 9-orbit frame marker.
// Ports: clock127 / reset (sync, active-high); bus (slave modport: enable,
//        orbit_length_minus_one, revo_mask, resync in; revo, frame9,
//        revo_rise, revo_fall, orbit_count, token out); remote_revo_p/n
//        (differential DDR line carrying clock127 XOR revo).
module revo_frame9_transmitter #(
    parameter int DEFAULT_ORBIT_MINUS_ONE = revo_frame9_transmitter_pkg::DEFAULT_ORBIT_MINUS_ONE,
    parameter int MIN_ORBIT_MINUS_ONE     = 15
) (
    input  logic                        clock127,
    input  logic                        reset,
    revo_frame9_transmitter_if.slave    bus,
    output logic                        remote_revo_p,
    output logic                        remote_revo_n
);
    import revo_frame9_transmitter_pkg::*;

    // The clamp floor may never exceed the nominal orbit length.
    localparam logic [ORBIT_CTR_W-1:0] MIN_LEN_C =
        (MIN_ORBIT_MINUS_ONE > DEFAULT_ORBIT_MINUS_ONE) ?
        ORBIT_CTR_W'(DEFAULT_ORBIT_MINUS_ONE) : ORBIT_CTR_W'(MIN_ORBIT_MINUS_ONE);

    logic [ORBIT_CTR_W-1:0] ctr_r;
    logic [ORBIT_CTR_W-1:0] ctr_next_s;
    logic [ORBIT_CTR_W-1:0] len_shadow_r;
    logic [ORBIT_CTR_W-1:0] len_shadow_next_s;
    logic [ORBIT_CTR_W-1:0] len_sample_s;
    logic [8:0]             token_r;
    logic [8:0]             token_next_s;
    logic [8:0]             new_token_s;
    logic [31:0]            orbit_count_r;
    logic [31:0]            orbit_count_next_s;
    logic                   boundary_s;
    logic                   revo_next_s;
    logic                   frame9_next_s;
    logic                   revo_r;
    logic                   frame9_r;
    logic                   revo_rise_r;
    logic                   revo_fall_r;

    // Boundary decision and next-state of counter, token, length shadow and strobes.
    always_comb begin
        len_sample_s       = clamp_orbit(bus.orbit_length_minus_one, MIN_LEN_C);
        boundary_s         = bus.resync | (ctr_r == len_shadow_r);
        new_token_s        = rotate_token(token_r);
        ctr_next_s         = ctr_r + 11'd1;
        token_next_s       = token_r;
        orbit_count_next_s = orbit_count_r;
        len_shadow_next_s  = len_shadow_r;
        revo_next_s        = 1'b0;
        frame9_next_s      = 1'b0;

        // A resync restarts the frame even when it lands on a natural wrap.
        if (bus.resync) begin
            new_token_s = FRAME9_TOKEN_INIT;
        end else begin
            new_token_s = rotate_token(token_r);
        end

        if (boundary_s) begin
            ctr_next_s         = 11'd0;
            token_next_s       = new_token_s;
            orbit_count_next_s = orbit_count_r + 32'd1;
            revo_next_s        = bus.enable & ((bus.revo_mask & new_token_s) == 9'd0);
            frame9_next_s      = (new_token_s == FRAME9_TOKEN_INIT);
            // The period only changes at a frame start, so a frame is never
            // stretched or shortened part-way through.
            if (new_token_s == FRAME9_TOKEN_INIT) begin
                len_shadow_next_s = len_sample_s;
            end else begin
                len_shadow_next_s = len_shadow_r;
            end
        end else begin
            ctr_next_s        = ctr_r + 11'd1;
            len_shadow_next_s = len_shadow_r;
        end
    end

    // State and output registers; reset aborts the orbit and dominates resync.
    always_ff @(posedge clock127) begin
        if (reset) begin
            ctr_r         <= 11'd0;
            len_shadow_r  <= len_sample_s;
            token_r       <= FRAME9_TOKEN_INIT;
            orbit_count_r <= 32'd0;
            revo_r        <= 1'b0;
            frame9_r      <= 1'b0;
            revo_rise_r   <= 1'b1;
            revo_fall_r   <= 1'b0;
        end else begin
            ctr_r         <= ctr_next_s;
            len_shadow_r  <= len_shadow_next_s;
            token_r       <= token_next_s;
            orbit_count_r <= orbit_count_next_s;
            revo_r        <= revo_next_s;
            frame9_r      <= frame9_next_s;
            // Inverted in the high half, true in the low half: clock XOR revo.
            revo_rise_r   <= ~revo_next_s;
            revo_fall_r   <= revo_next_s;
        end
    end

    assign bus.revo        = revo_r;
    assign bus.frame9      = frame9_r;
    assign bus.revo_rise   = revo_rise_r;
    assign bus.revo_fall   = revo_fall_r;
    assign bus.orbit_count = orbit_count_r;
    assign bus.token       = token_r;

    ddr_revo_output u_ddr_revo_output (
        .clock127      (clock127),
        .revo_rise     (revo_rise_r),
        .revo_fall     (revo_fall_r),
        .remote_revo_p (remote_revo_p),
        .remote_revo_n (remote_revo_n)
    );

endmodule

// File: tb/tb_revo_frame9_transmitter.sv
// Directed bench for revo_frame9_transmitter: reset state, nominal cadence,
// masking, resync, mid-frame length change with clamping, disabled output,
// held resync, mid-orbit reset and the DDR line encoding.
module tb_revo_frame9_transmitter;
    import revo_frame9_transmitter_pkg::*;

    logic clock127 = 1'b0;
    logic reset;
    logic remote_revo_p;
    logic remote_revo_n;
    int   cyc = 0;
    int   total_cnt = 0;
    int   bad_cnt = 0;

    revo_frame9_transmitter_if bus ();

    revo_frame9_transmitter dut (
        .clock127      (clock127),
        .reset         (reset),
        .bus           (bus),
        .remote_revo_p (remote_revo_p),
        .remote_revo_n (remote_revo_n)
    );

    // 8 ns clock period.
    always #4 clock127 = ~clock127;

    // Rising-edge counter used as the time base for period measurements.
    always @(posedge clock127) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Step negedges until revo (want_f9=0) or frame9 (want_f9=1) is seen; -1 on timeout.
    task automatic wait_pulse(input bit want_f9, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock127);
            if ((want_f9 ? bus.frame9 : bus.revo) === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    // Observe n negedges, counting strobes, boundaries and line-encoding errors.
    task automatic run_window(input int n, output int revo_n, output int f9_n,
                              output int bnd_n, output int lsb_revo_n, output int line_bad);
        logic [31:0] prev;
        revo_n = 0; f9_n = 0; bnd_n = 0; lsb_revo_n = 0; line_bad = 0;
        prev = bus.orbit_count;
        for (int i = 0; i < n; i++) begin
            @(negedge clock127);
            if (bus.revo === 1'b1) revo_n++;
            if (bus.frame9 === 1'b1) f9_n++;
            if (bus.orbit_count !== prev) begin
                bnd_n++;
                prev = bus.orbit_count;
                if (bus.token[0] === 1'b1 && bus.revo === 1'b1) lsb_revo_n++;
            end
            if (remote_revo_p !== bus.revo || remote_revo_n !== ~remote_revo_p ||
                bus.revo_rise !== ~bus.revo || bus.revo_fall !== bus.revo) line_bad++;
        end
    endtask

    initial begin
        int c0, t1, t2, tf, tf2, tr, tf3, tf4, tf5, t;
        int rn, fn, bn, ln, lb;

        reset = 1'b1;
        bus.enable = 1'b1;
        bus.orbit_length_minus_one = 11'd1279;
        bus.revo_mask = 9'd0;
        bus.resync = 1'b0;
        repeat (4) @(negedge clock127);

        check_val("rst_revo", {63'd0, bus.revo}, 64'd0);
        check_val("rst_frame9", {63'd0, bus.frame9}, 64'd0);
        check_val("rst_rise", {63'd0, bus.revo_rise}, 64'd1);
        check_val("rst_fall", {63'd0, bus.revo_fall}, 64'd0);
        check_val("rst_count", {32'd0, bus.orbit_count}, 64'd0);
        check_val("rst_token", {55'd0, bus.token}, 64'd256);

        // Nominal cadence from reset release.
        reset = 1'b0;
        c0 = cyc;
        wait_pulse(1'b0, 1400, t1);
        check_val("first_revo_delay", 64'(t1 - c0), 64'd1280);
        check_val("first_token", {55'd0, bus.token}, 64'd128);
        check_val("first_no_frame9", {63'd0, bus.frame9}, 64'd0);
        wait_pulse(1'b0, 1400, t2);
        check_val("revo_period", 64'(t2 - t1), 64'd1280);
        wait_pulse(1'b1, 12000, tf);
        check_val("first_frame9_delay", 64'(tf - c0), 64'd11520);
        check_val("frame9_count", {32'd0, bus.orbit_count}, 64'd9);
        check_val("frame9_revo", {63'd0, bus.revo}, 64'd1);
        check_val("frame9_token", {55'd0, bus.token}, 64'd256);

        // Mask bit 0 drops the revo of the orbit whose token is 9'b000000001.
        bus.revo_mask = 9'b000000001;
        run_window(11520, rn, fn, bn, ln, lb);
        check_val("mask_revo_cnt", 64'(rn), 64'd8);
        check_val("mask_f9_cnt", 64'(fn), 64'd1);
        check_val("mask_bnd_cnt", 64'(bn), 64'd9);
        check_val("mask_lsb_revo", 64'(ln), 64'd0);
        check_val("mask_line", 64'(lb), 64'd0);
        check_val("mask_frame9_end", {63'd0, bus.frame9}, 64'd1);
        check_val("mask_count", {32'd0, bus.orbit_count}, 64'd18);
        tf2 = cyc;
        bus.revo_mask = 9'd0;

        // Resync at ctr == 600.
        repeat (600) @(negedge clock127);
        check_val("pre_resync_pos", 64'(cyc - tf2), 64'd600);
        bus.resync = 1'b1;
        @(negedge clock127);
        bus.resync = 1'b0;
        tr = cyc;
        check_val("resync_revo", {63'd0, bus.revo}, 64'd1);
        check_val("resync_frame9", {63'd0, bus.frame9}, 64'd1);
        check_val("resync_token", {55'd0, bus.token}, 64'd256);
        check_val("resync_count", {32'd0, bus.orbit_count}, 64'd19);
        wait_pulse(1'b0, 1400, t);
        check_val("post_resync_period", 64'(t - tr), 64'd1280);
        check_val("post_resync_token", {55'd0, bus.token}, 64'd128);

        // Length change mid-frame only takes effect at the next frame start.
        bus.orbit_length_minus_one = 11'd99;
        wait_pulse(1'b1, 11000, tf3);
        check_val("len99_frame_hold", 64'(tf3 - t), 64'd10240);
        wait_pulse(1'b0, 200, t);
        check_val("len99_period", 64'(t - tf3), 64'd100);
        bus.orbit_length_minus_one = 11'd3;
        wait_pulse(1'b1, 1000, tf4);
        check_val("len3_frame_hold", 64'(tf4 - tf3), 64'd900);
        wait_pulse(1'b0, 100, t);
        check_val("len3_clamped_period", 64'(t - tf4), 64'd16);
        wait_pulse(1'b1, 300, tf5);
        check_val("len3_frame", 64'(tf5 - tf4), 64'd144);

        // Disabled: line idles at clock127, orbits keep counting.
        bus.orbit_length_minus_one = 11'd1279;
        bus.enable = 1'b0;
        bus.resync = 1'b1;
        @(negedge clock127);
        bus.resync = 1'b0;
        check_val("dis_resync_frame9", {63'd0, bus.frame9}, 64'd1);
        check_val("dis_resync_revo", {63'd0, bus.revo}, 64'd0);
        @(posedge clock127);
        #1;
        check_val("dis_line_high", {63'd0, remote_revo_p}, 64'd1);
        run_window(2560, rn, fn, bn, ln, lb);
        check_val("dis_revo_cnt", 64'(rn), 64'd0);
        check_val("dis_f9_cnt", 64'(fn), 64'd0);
        check_val("dis_bnd_cnt", 64'(bn), 64'd2);
        check_val("dis_line", 64'(lb), 64'd0);

        // Resync held high: a boundary, frame9 and revo every cycle.
        bus.enable = 1'b1;
        bus.resync = 1'b1;
        run_window(5, rn, fn, bn, ln, lb);
        bus.resync = 1'b0;
        check_val("hold_revo_cnt", 64'(rn), 64'd5);
        check_val("hold_f9_cnt", 64'(fn), 64'd5);
        check_val("hold_bnd_cnt", 64'(bn), 64'd5);
        check_val("hold_line", 64'(lb), 64'd0);

        // Reset mid-orbit dominates a coincident resync.
        repeat (300) @(negedge clock127);
        reset = 1'b1;
        bus.resync = 1'b1;
        @(negedge clock127);
        bus.resync = 1'b0;
        check_val("midrst_revo", {63'd0, bus.revo}, 64'd0);
        check_val("midrst_frame9", {63'd0, bus.frame9}, 64'd0);
        check_val("midrst_count", {32'd0, bus.orbit_count}, 64'd0);
        check_val("midrst_token", {55'd0, bus.token}, 64'd256);
        @(negedge clock127);
        reset = 1'b0;
        c0 = cyc;
        wait_pulse(1'b0, 1400, t);
        check_val("midrst_first_revo", 64'(t - c0), 64'd1280);
        check_val("midrst_first_token", {55'd0, bus.token}, 64'd128);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
